// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter: controller state
// encoding, default parameter values and the tag-width helper.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_CALIB = 2'd0,
        ST_IDLE       = 2'd1,
        ST_ISSUE      = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_PORTS  = 2;
    localparam int DEF_ADDR_WIDTH = 27;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_MASK_WIDTH = 16;
    localparam int DEF_TAG_DEPTH  = 4;

    // Bits needed to name a port index; never narrower than one bit.
    function automatic int tag_width(input int num_ports);
        int w;
        w = 1;
        while ((32'sd1 << w) < num_ports) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dram_arb_tag_fifo.sv
// Read-tag FIFO: remembers which port issued each outstanding read so the
// in-order read data can be steered back. Head entry is visible on pop_data.
module dram_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                       (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r[PW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[PW-1:0]] <= push_data;
                wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one DRAM controller command port among several
// clients, with in-order read return steering. DRAM_ARB_PERF_EN adds counters.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MASK_WIDTH = DEF_MASK_WIDTH,
    parameter int TAG_DEPTH  = DEF_TAG_DEPTH
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [NUM_PORTS-1:0]            port_ren,
    input  logic [NUM_PORTS-1:0]            port_wen,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0] port_wmask,
    output logic [NUM_PORTS-1:0]            port_ready,
    output logic [DATA_WIDTH-1:0]           port_rdata,
    output logic [NUM_PORTS-1:0]            port_rdata_valid,
    output logic                            dram_ren,
    output logic                            dram_wen,
    output logic [ADDR_WIDTH-1:0]           dram_addr,
    output logic [DATA_WIDTH-1:0]           dram_wdata,
    output logic [MASK_WIDTH-1:0]           dram_wmask,
    input  logic                            dram_busy,
    input  logic                            dram_init_calib_complete,
    input  logic [DATA_WIDTH-1:0]           dram_rdata,
    input  logic                            dram_rdata_valid,
    output logic                            err_orphan,
    output logic [NUM_PORTS*32-1:0]         perf_count
);

    localparam int TW = tag_width(NUM_PORTS);

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    logic [TW-1:0]         prio_r;
    logic [TW-1:0]         grant_idx_s;
    logic                  grant_vld_s;
    logic                  grant_wr_s;
    logic                  accept_s;
    logic [NUM_PORTS-1:0]  eligible_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [MASK_WIDTH-1:0] sel_wmask_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  fifo_pop_s;
    logic [TW-1:0]         fifo_head_s;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NUM_PORTS) ? (s - NUM_PORTS) : s;
    endfunction

    // A read cannot be granted without a free tag slot; writes always can.
    assign eligible_s = port_wen | (port_ren & {NUM_PORTS{~fifo_full_s}});

    // Round-robin search starting at the port after the last grant.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {TW{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!grant_vld_s && eligible_s[wrap_idx(int'(prio_r), k)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = TW'(wrap_idx(int'(prio_r), k));
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    assign accept_s   = (state_r == ST_IDLE) && dram_init_calib_complete && grant_vld_s;
    assign grant_wr_s = port_wen[grant_idx_s];

    // Ready strobe for the single granted port.
    always_comb begin
        port_ready = {NUM_PORTS{1'b0}};
        if (accept_s) begin
            port_ready[grant_idx_s] = 1'b1;
        end else begin
            port_ready = {NUM_PORTS{1'b0}};
        end
    end

    // Payload of the granted port.
    always_comb begin
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_wdata_s = {DATA_WIDTH{1'b0}};
        sel_wmask_s = {MASK_WIDTH{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (int'(grant_idx_s) == i) begin
                sel_addr_s  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_s = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wmask_s = port_wmask[i*MASK_WIDTH +: MASK_WIDTH];
            end else begin
                sel_addr_s  = sel_addr_s;
            end
        end
    end

    // Next-state logic; losing calibration only takes effect outside ISSUE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT_CALIB: begin
                if (dram_init_calib_complete) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_CALIB;
                end
            end
            ST_IDLE: begin
                if (!dram_init_calib_complete) begin
                    state_nxt_s = ST_WAIT_CALIB;
                end else if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (dram_busy) begin
                    state_nxt_s = ST_ISSUE;
                end else if (dram_init_calib_complete) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_CALIB;
                end
            end
            default: state_nxt_s = ST_WAIT_CALIB;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_WAIT_CALIB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Round-robin pointer advances past each accepted port.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prio_r <= {TW{1'b0}};
        end else if (accept_s) begin
            prio_r <= (grant_idx_s == TW'(NUM_PORTS - 1)) ? {TW{1'b0}}
                                                          : grant_idx_s + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Command register: a request with both enables set is issued as a write.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dram_ren   <= 1'b0;
            dram_wen   <= 1'b0;
            dram_addr  <= {ADDR_WIDTH{1'b0}};
            dram_wdata <= {DATA_WIDTH{1'b0}};
            dram_wmask <= {MASK_WIDTH{1'b0}};
        end else if (accept_s) begin
            dram_ren   <= ~grant_wr_s;
            dram_wen   <= grant_wr_s;
            dram_addr  <= sel_addr_s;
            dram_wdata <= sel_wdata_s;
            dram_wmask <= sel_wmask_s;
        end else if ((state_r == ST_ISSUE) && !dram_busy) begin
            dram_ren   <= 1'b0;
            dram_wen   <= 1'b0;
        end
    end

    dram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TW)
    ) u_tag_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (accept_s && !grant_wr_s),
        .push_data (grant_idx_s),
        .pop       (dram_rdata_valid),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign fifo_pop_s = dram_rdata_valid && !fifo_empty_s;
    assign port_rdata = fifo_pop_s ? dram_rdata : {DATA_WIDTH{1'b0}};

    // Return strobe to the port at the head of the tag FIFO.
    always_comb begin
        port_rdata_valid = {NUM_PORTS{1'b0}};
        if (fifo_pop_s) begin
            port_rdata_valid[fifo_head_s] = 1'b1;
        end else begin
            port_rdata_valid = {NUM_PORTS{1'b0}};
        end
    end

    // Sticky flag for read data that arrives with no outstanding tag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_orphan <= 1'b0;
        end else if (dram_rdata_valid && fifo_empty_s) begin
            err_orphan <= 1'b1;
        end
    end

`ifdef DRAM_ARB_PERF_EN
    logic [31:0] perf_cnt_r [NUM_PORTS];

    // Saturating per-port accepted-command counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                perf_cnt_r[i] <= 32'd0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((int'(grant_idx_s) == i) && (perf_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    perf_cnt_r[i] <= perf_cnt_r[i] + 32'd1;
                end
            end
        end
    end

    // Pack counters onto the flat output bus.
    always_comb begin
        perf_count = {(NUM_PORTS*32){1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            perf_count[i*32 +: 32] = perf_cnt_r[i];
        end
    end
`else
    assign perf_count = {(NUM_PORTS*32){1'b0}};
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus a
// randomized run against a queue-based transaction model.
module tb_dram_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 27;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int TD = 4;
`ifdef DRAM_ARB_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             resetn;
    logic [NP-1:0]    port_ren, port_wen, port_ready, port_rdata_valid;
    logic [NP*AW-1:0] port_addr;
    logic [NP*DW-1:0] port_wdata;
    logic [NP*MW-1:0] port_wmask;
    logic [DW-1:0]    port_rdata, dram_wdata, dram_rdata;
    logic             dram_ren, dram_wen, dram_busy, dram_init_calib_complete;
    logic             dram_rdata_valid, err_orphan;
    logic [AW-1:0]    dram_addr;
    logic [MW-1:0]    dram_wmask;
    logic [NP*32-1:0] perf_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    dram_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TAG_DEPTH(TD)
    ) dut (
        .clock(clock), .resetn(resetn),
        .port_ren(port_ren), .port_wen(port_wen), .port_addr(port_addr),
        .port_wdata(port_wdata), .port_wmask(port_wmask), .port_ready(port_ready),
        .port_rdata(port_rdata), .port_rdata_valid(port_rdata_valid),
        .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_busy(dram_busy),
        .dram_init_calib_complete(dram_init_calib_complete),
        .dram_rdata(dram_rdata), .dram_rdata_valid(dram_rdata_valid),
        .err_orphan(err_orphan), .perf_count(perf_count)
    );

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic clear_inputs();
        port_ren = '0; port_wen = '0; port_addr = '0; port_wdata = '0; port_wmask = '0;
        dram_busy = 1'b0; dram_rdata = '0; dram_rdata_valid = 1'b0;
    endtask

    // Ends just after a negedge with reset released and the DUT in WAIT_CALIB.
    task automatic do_reset(input logic calib);
        @(negedge clock);
        resetn = 1'b0;
        clear_inputs();
        dram_init_calib_complete = calib;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        dram_init_calib_complete = 1'b1;
        port_ren = '1;
        @(negedge clock);
        #1;
        total++;
        if (port_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", port_ready); end
        total++;
        if ({dram_ren, dram_wen} !== 2'b00) begin bad++; $display("FAIL reset_cmd: got %b want 00", {dram_ren, dram_wen}); end
        total++;
        if ({dram_addr, dram_wdata, dram_wmask} !== '0) begin bad++; $display("FAIL reset_payload: got %h want 0", {dram_addr, dram_wdata, dram_wmask}); end
        total++;
        if ({err_orphan, port_rdata_valid, port_rdata} !== '0) begin bad++; $display("FAIL reset_return: got %h want 0", {err_orphan, port_rdata_valid, port_rdata}); end
        total++;
        if (perf_count !== '0) begin bad++; $display("FAIL reset_perf: got %h want 0", perf_count); end
    endtask

    task automatic test_calib();
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        a0 = 27'h5A5A5A5;
        d0 = 64'hDEAD_BEEF_0123_4567;
        do_reset(1'b0);
        port_ren[0] = 1'b1;
        port_addr[0 +: AW] = a0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (port_ready !== 3'b000 || dram_ren !== 1'b0) begin
                bad++; $display("FAIL calib_low_block: ready %b ren %b want 000/0", port_ready, dram_ren);
            end
            @(negedge clock);
        end
        dram_init_calib_complete = 1'b1;
        #1;
        total++;
        if (port_ready !== 3'b000) begin bad++; $display("FAIL calib_edge_ready: got %b want 000", port_ready); end
        @(negedge clock);
        #1;
        total++;
        if (port_ready !== 3'b001) begin bad++; $display("FAIL calib_grant: got %b want 001", port_ready); end
        @(negedge clock);
        port_ren = '0;
        #1;
        total++;
        if ({dram_ren, dram_wen} !== 2'b10 || dram_addr !== a0) begin
            bad++; $display("FAIL calib_issue: ren/wen %b addr %h want 10 addr %h", {dram_ren, dram_wen}, dram_addr, a0);
        end
        total++;
        if (perf_count[0 +: 32] !== (PERF_ON ? 32'd1 : 32'd0)) begin
            bad++; $display("FAIL calib_perf: got %0d want %0d", perf_count[0 +: 32], PERF_ON ? 1 : 0);
        end
        @(negedge clock);
        dram_rdata = d0;
        dram_rdata_valid = 1'b1;
        #1;
        total++;
        if (dram_ren !== 1'b0) begin bad++; $display("FAIL calib_issue_end: got %b want 0", dram_ren); end
        total++;
        if (port_rdata_valid !== 3'b001 || port_rdata !== d0) begin
            bad++; $display("FAIL calib_return: valid %b data %h want 001 %h", port_rdata_valid, port_rdata, d0);
        end
        @(negedge clock);
        dram_rdata_valid = 1'b0;
        #1;
        total++;
        if (err_orphan !== 1'b0) begin bad++; $display("FAIL calib_no_orphan: got %b want 0", err_orphan); end
    endtask

    task automatic test_round_robin();
        int grants;
        int exp_cnt [NP];
        int p;
        do_reset(1'b1);
        @(negedge clock);
        for (int i = 0; i < NP; i++) begin
            exp_cnt[i] = 0;
            port_addr[i*AW +: AW] = AW'($urandom);
            port_wdata[i*DW +: DW] = {$urandom, $urandom};
        end
        port_wen = '1;
        grants = 0;
        for (int cyc = 0; cyc < 30 && grants < 6; cyc++) begin
            #1;
            if (port_ready !== 3'b000) begin
                p = grants % NP;
                total++;
                if (port_ready !== onehot(p)) begin
                    bad++; $display("FAIL rr_order grant %0d: got %b want %b", grants, port_ready, onehot(p));
                end
                total++;
                if (perf_count[p*32 +: 32] !== (PERF_ON ? 32'(exp_cnt[p]) : 32'd0)) begin
                    bad++; $display("FAIL rr_perf_step port %0d: got %0d want %0d", p, perf_count[p*32 +: 32], PERF_ON ? exp_cnt[p] : 0);
                end
                exp_cnt[p]++;
                grants++;
            end
            @(negedge clock);
        end
        total++;
        if (grants != 6) begin bad++; $display("FAIL rr_grant_count: got %0d want 6", grants); end
        port_wen = '0;
        #1;
        for (int i = 0; i < NP; i++) begin
            total++;
            if (perf_count[i*32 +: 32] !== (PERF_ON ? 32'd2 : 32'd0)) begin
                bad++; $display("FAIL rr_perf_final port %0d: got %0d want %0d", i, perf_count[i*32 +: 32], PERF_ON ? 2 : 0);
            end
        end
    endtask

    task automatic test_busy_hold();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        do_reset(1'b1);
        @(negedge clock);
        for (int i = 0; i < NP; i++) begin
            port_addr[i*AW +: AW] = AW'($urandom);
            port_wdata[i*DW +: DW] = {$urandom, $urandom};
            port_wmask[i*MW +: MW] = MW'($urandom);
        end
        a = port_addr[0 +: AW];
        d = port_wdata[0 +: DW];
        m = port_wmask[0 +: MW];
        port_wen = '1;
        dram_busy = 1'b1;
        #1;
        total++;
        if (port_ready !== 3'b001) begin bad++; $display("FAIL busy_first_grant: got %b want 001", port_ready); end
        @(negedge clock);
        port_wdata[0 +: DW] = ~d;
        port_addr[0 +: AW] = ~a;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) dram_busy = 1'b0;
            #1;
            total++;
            if (dram_wen !== 1'b1 || dram_ren !== 1'b0 || dram_addr !== a || dram_wdata !== d ||
                dram_wmask !== m || port_ready !== 3'b000) begin
                bad++; $display("FAIL busy_hold cycle %0d: wen %b addr %h data %h mask %h ready %b want 1 %h %h %h 000",
                                i, dram_wen, dram_addr, dram_wdata, dram_wmask, port_ready, a, d, m);
            end
            @(negedge clock);
        end
        #1;
        total++;
        if (dram_wen !== 1'b0 || port_ready !== 3'b010) begin
            bad++; $display("FAIL busy_release: wen %b ready %b want 0 010", dram_wen, port_ready);
        end
        @(negedge clock);
        port_wen = '0;
    endtask

    task automatic test_tag_full();
        int seq [4];
        logic [DW-1:0] d;
        seq = '{1, 0, 1, 0};
        do_reset(1'b1);
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            port_ren = onehot(seq[k]);
            port_addr[seq[k]*AW +: AW] = AW'(k + 16);
            #1;
            total++;
            if (port_ready !== onehot(seq[k])) begin
                bad++; $display("FAIL tag_read_grant %0d: got %b want %b", k, port_ready, onehot(seq[k]));
            end
            @(negedge clock);
            port_ren = '0;
            #1;
            total++;
            if (dram_ren !== 1'b1 || dram_addr !== AW'(k + 16)) begin
                bad++; $display("FAIL tag_read_issue %0d: ren %b addr %h want 1 %h", k, dram_ren, dram_addr, AW'(k + 16));
            end
            @(negedge clock);
        end
        port_ren = 3'b011;
        port_wen = 3'b100;
        #1;
        total++;
        if (port_ready !== 3'b100) begin bad++; $display("FAIL tag_full_write_ok: got %b want 100", port_ready); end
        @(negedge clock);
        port_wen = '0;
        #1;
        total++;
        if (dram_wen !== 1'b1) begin bad++; $display("FAIL tag_full_write_issue: got %b want 1", dram_wen); end
        @(negedge clock);
        #1;
        total++;
        if (port_ready !== 3'b000) begin bad++; $display("FAIL tag_full_read_block: got %b want 000", port_ready); end
        @(negedge clock);
        port_ren = '0;
        for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom};
            dram_rdata = d;
            dram_rdata_valid = 1'b1;
            #1;
            total++;
            if (port_rdata_valid !== onehot(seq[k]) || port_rdata !== d) begin
                bad++; $display("FAIL tag_return %0d: valid %b data %h want %b %h", k, port_rdata_valid, port_rdata, onehot(seq[k]), d);
            end
            @(negedge clock);
        end
        dram_rdata_valid = 1'b0;
        #1;
        total++;
        if (err_orphan !== 1'b0) begin bad++; $display("FAIL tag_no_orphan: got %b want 0", err_orphan); end
    endtask

    task automatic test_orphan();
        do_reset(1'b1);
        @(negedge clock);
        dram_rdata = {$urandom, $urandom};
        dram_rdata_valid = 1'b1;
        #1;
        total++;
        if (port_rdata_valid !== 3'b000 || port_rdata !== '0) begin
            bad++; $display("FAIL orphan_dropped: valid %b data %h want 000 0", port_rdata_valid, port_rdata);
        end
        @(negedge clock);
        dram_rdata_valid = 1'b0;
        #1;
        total++;
        if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
        repeat (5) @(negedge clock);
        #1;
        total++;
        if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
        resetn = 1'b0;
        #1;
        total++;
        if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_cleared: got %b want 0", err_orphan); end
    endtask

    task automatic test_reset_mid_issue();
        do_reset(1'b1);
        @(negedge clock);
        port_ren[0] = 1'b1;
        dram_busy = 1'b1;
        #1;
        total++;
        if (port_ready !== 3'b001) begin bad++; $display("FAIL mid_grant: got %b want 001", port_ready); end
        @(negedge clock);
        port_ren = '0;
        #1;
        total++;
        if (dram_ren !== 1'b1) begin bad++; $display("FAIL mid_issue: got %b want 1", dram_ren); end
        resetn = 1'b0;
        #1;
        total++;
        if ({dram_ren, dram_wen} !== 2'b00 || dram_addr !== '0 || port_ready !== 3'b000) begin
            bad++; $display("FAIL mid_async_clear: cmd %b addr %h ready %b want 00 0 000", {dram_ren, dram_wen}, dram_addr, port_ready);
        end
        @(negedge clock);
        dram_busy = 1'b0;
        dram_init_calib_complete = 1'b0;
        resetn = 1'b1;
        port_wen[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (port_ready !== 3'b000) begin bad++; $display("FAIL mid_wait_calib %0d: got %b want 000", i, port_ready); end
            @(negedge clock);
        end
        dram_init_calib_complete = 1'b1;
        @(negedge clock);
        #1;
        total++;
        if (port_ready !== 3'b001) begin bad++; $display("FAIL mid_regrant: got %b want 001", port_ready); end
        @(negedge clock);
        port_wen = '0;
        @(negedge clock);
        dram_rdata_valid = 1'b1;
        #1;
        total++;
        if (port_rdata_valid !== 3'b000) begin bad++; $display("FAIL mid_fifo_empty: got %b want 000", port_rdata_valid); end
        @(negedge clock);
        dram_rdata_valid = 1'b0;
        #1;
        total++;
        if (err_orphan !== 1'b1) begin bad++; $display("FAIL mid_stale_tag_gone: got %b want 1", err_orphan); end
    endtask

    task automatic test_random();
        bit            m_cal, m_iss, m_wen, m_orphan;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
        logic [MW-1:0] m_wmask;
        logic [31:0]   m_cnt [NP];
        int            tagq [$];
        int            m_next, g, idx;
        logic [NP-1:0] exp_ready, exp_rv;
        logic [DW-1:0] exp_rd;
        logic [NP*32-1:0] exp_perf;
        do_reset(1'b1);
        m_cal = 1'b0; m_iss = 1'b0; m_wen = 1'b0; m_orphan = 1'b0;
        m_addr = '0; m_wdata = '0; m_wmask = '0; m_next = 0;
        for (int i = 0; i < NP; i++) m_cnt[i] = 32'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NP; i++) begin
                port_ren[i] = ($urandom_range(0, 2) == 0);
                port_wen[i] = ($urandom_range(0, 4) == 0);
                port_addr[i*AW +: AW] = AW'($urandom);
                port_wdata[i*DW +: DW] = {$urandom, $urandom};
                port_wmask[i*MW +: MW] = MW'($urandom);
            end
            dram_busy = ($urandom_range(0, 2) == 0);
            dram_init_calib_complete = ($urandom_range(0, 39) != 0);
            dram_rdata = {$urandom, $urandom};
            dram_rdata_valid = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
            exp_ready = '0;
            g = -1;
            if (m_cal && !m_iss && dram_init_calib_complete) begin
                for (int k = 0; k < NP; k++) begin
                    idx = (m_next + k) % NP;
                    if (g < 0 && (port_wen[idx] || (port_ren[idx] && tagq.size() < TD))) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_rv = '0;
            exp_rd = '0;
            if (dram_rdata_valid && tagq.size() > 0) begin
                exp_rv[tagq[0]] = 1'b1;
                exp_rd = dram_rdata;
            end
            for (int i = 0; i < NP; i++) exp_perf[i*32 +: 32] = PERF_ON ? m_cnt[i] : 32'd0;
            #1;
            total++;
            if (port_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, port_ready, exp_ready); end
            total++;
            if (port_rdata_valid !== exp_rv || port_rdata !== exp_rd) begin
                bad++; $display("FAIL rnd_return cyc %0d: valid %b data %h want %b %h", cyc, port_rdata_valid, port_rdata, exp_rv, exp_rd);
            end
            total++;
            if ({dram_ren, dram_wen} !== {m_iss && !m_wen, m_iss && m_wen} ||
                dram_addr !== m_addr || dram_wdata !== m_wdata || dram_wmask !== m_wmask) begin
                bad++; $display("FAIL rnd_cmd cyc %0d: cmd %b addr %h data %h mask %h want %b %h %h %h", cyc,
                                {dram_ren, dram_wen}, dram_addr, dram_wdata, dram_wmask,
                                {m_iss && !m_wen, m_iss && m_wen}, m_addr, m_wdata, m_wmask);
            end
            total++;
            if (err_orphan !== m_orphan || perf_count !== exp_perf) begin
                bad++; $display("FAIL rnd_status cyc %0d: orphan %b perf %h want %b %h", cyc, err_orphan, perf_count, m_orphan, exp_perf);
            end
            if (dram_rdata_valid) begin
                if (tagq.size() > 0) void'(tagq.pop_front());
                else m_orphan = 1'b1;
            end
            if (!m_cal) begin
                m_cal = dram_init_calib_complete;
            end else if (m_iss) begin
                if (!dram_busy) begin
                    m_iss = 1'b0;
                    m_cal = dram_init_calib_complete;
                end
            end else if (!dram_init_calib_complete) begin
                m_cal = 1'b0;
            end else if (g >= 0) begin
                m_iss   = 1'b1;
                m_wen   = port_wen[g];
                m_addr  = port_addr[g*AW +: AW];
                m_wdata = port_wdata[g*DW +: DW];
                m_wmask = port_wmask[g*MW +: MW];
                if (!port_wen[g]) tagq.push_back(g);
                if (m_cnt[g] != 32'hFFFF_FFFF) m_cnt[g] = m_cnt[g] + 32'd1;
                m_next = (g + 1) % NP;
            end
            @(negedge clock);
        end
        clear_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        dram_init_calib_complete = 1'b0;
        test_reset();
        test_calib();
        test_round_robin();
        test_busy_hold();
        test_tag_full();
        test_orphan();
        test_reset_mid_issue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
